cpu_mem_sequencer: RTL and testbench

Multicycle sequencer placed between the cpu core and a single shared instruction/data memory port with a valid/ready handshake. It serialises fetch and data access per instruction. It tolerates any number of bus wait states and commits the core state with a one-cycle enable pulse. It also adds halt and single-step control, a bus timeout/fault trap and a retired-instruction counter.

---
 rtl/cpu_pkg.sv | 12 +
 rtl/bus_wait_timer.sv | 19 +
 rtl/cpu_mem_sequencer.sv | 95 +++++++++
 tb/tb_cpu_mem_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared sequencer state encoding, default widths and bus command type.
package cpu_pkg;
  localparam int XLEN_DEF = 32;
  localparam int ADDR_W_DEF = 32;
  typedef enum logic [2:0] {FETCH, DECODE, MEM, COMMIT, HALTED, FAULT} state_e;
  typedef struct packed {
    logic req;
    logic we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [XLEN_DEF-1:0] wdata;
  } bus_cmd_t;
endpackage

// File: rtl/bus_wait_timer.sv
// bus_wait_timer: counts bus wait states of one transfer and flags a timeout.
module bus_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_wait,
  output logic o_timeout
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_cnt <= '0;
    else if (i_clear) r_cnt <= '0;
    else if (i_wait) r_cnt <= r_cnt + 1'b1;
  // fires on the wait cycle that brings the count to TIMEOUT
  assign o_timeout = (TIMEOUT != 0) && i_wait && (r_cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/cpu_mem_sequencer.sv
// cpu_mem_sequencer: multicycle fetch/data sequencer between core and a shared
// valid/ready memory port, with halt/step control, bus fault trap and instret.
module cpu_mem_sequencer
  import cpu_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] core_pc,
  input  logic              core_mem_re,
  input  logic              core_mem_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [XLEN-1:0]   core_wdata,
  output logic [XLEN-1:0]   core_instr,
  output logic [XLEN-1:0]   core_rdata,
  output logic              core_en,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [XLEN-1:0]   bus_wdata,
  input  logic              bus_ready,
  input  logic [XLEN-1:0]   bus_rdata,
  input  logic              bus_err,
  input  logic              halt_req,
  input  logic              step,
  output logic              halted,
  output logic              fault,
  output logic [CNT_W-1:0]  instret
);
  state_e r_state, w_next;
  logic r_we, r_step;
  logic [XLEN-1:0] r_instr, r_rdata;
  logic [CNT_W-1:0] r_instret;
  bus_cmd_t w_cmd;
  logic w_xfer, w_ok, w_timeout;
  // request is gated by reset so it drops the moment reset asserts
  always_comb begin
    w_cmd = '0;
    w_cmd.req = reset && (r_state == FETCH || r_state == MEM);
    w_cmd.we = (r_state == MEM) && r_we;
    w_cmd.addr = (r_state == MEM) ? core_addr : core_pc;
    w_cmd.wdata = (r_state == MEM) ? core_wdata : '0;
  end
  assign bus_req = w_cmd.req;
  assign bus_we = w_cmd.we;
  assign bus_addr = w_cmd.addr;
  assign bus_wdata = w_cmd.wdata;
  assign w_xfer = w_cmd.req && bus_ready;
  assign w_ok = w_xfer && !bus_err;
  bus_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk(clk),
    .reset(reset),
    .i_clear(!w_cmd.req),
    .i_wait(w_cmd.req && !bus_ready),
    .o_timeout(w_timeout)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH, MEM: w_next = (w_timeout || (w_xfer && bus_err)) ? FAULT :
                           !w_ok ? r_state : (r_state == FETCH) ? DECODE : COMMIT;
      DECODE:     w_next = (core_mem_we || core_mem_re) ? MEM : COMMIT;
      COMMIT:     w_next = (halt_req || r_step) ? HALTED : FETCH;
      HALTED:     w_next = (step || !halt_req) ? FETCH : HALTED;
      default:    w_next = FAULT;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state <= FETCH;
      r_we <= 1'b0;
      r_step <= 1'b0;
      r_instr <= '0;
      r_rdata <= '0;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == DECODE) r_we <= core_mem_we;
      if (r_state == HALTED && step) r_step <= 1'b1;
      else if (r_state == COMMIT) r_step <= 1'b0;
      if (r_state == FETCH && w_ok) r_instr <= bus_rdata;
      if (r_state == MEM && w_ok && !r_we) r_rdata <= bus_rdata;
      if (r_state == COMMIT) r_instret <= r_instret + 1'b1;
    end
  assign core_instr = r_instr;
  assign core_rdata = r_rdata;
  assign instret = r_instret;
  assign core_en = r_state == COMMIT;
  assign halted = r_state == HALTED;
  assign fault = r_state == FAULT;
endmodule

// File: tb/tb_cpu_mem_sequencer.sv
// tb_cpu_mem_sequencer: directed and randomized instruction timelines checked
// against a memory/retire model kept in the bench.
module tb_cpu_mem_sequencer;
  localparam int CW = 3;
  logic clk = 1'b0, reset = 1'b0;
  logic [31:0] core_pc = '0, core_addr = '0, core_wdata = '0;
  logic core_mem_re = 1'b0, core_mem_we = 1'b0;
  logic [31:0] core_instr, core_rdata, bus_addr, bus_wdata;
  logic core_en, bus_req, bus_we, halted, fault;
  logic bus_ready = 1'b0, bus_err = 1'b0, halt_req = 1'b0, step = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic [CW-1:0] instret;
  int checks = 0, errors = 0, retired = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] pc = '0, exp_rdata = '0, last_instr = '0;

  always #5 clk = ~clk;

  cpu_mem_sequencer #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .core_pc(core_pc), .core_mem_re(core_mem_re),
    .core_mem_we(core_mem_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_instr(core_instr), .core_rdata(core_rdata), .core_en(core_en),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata), .bus_err(bus_err),
    .halt_req(halt_req), .step(step), .halted(halted), .fault(fault), .instret(instret)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_fault", fault, 0);
    chk("rst_req", bus_req, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    retired = 0;
    exp_rdata = '0;
    last_instr = '0;
  endtask

  // one whole instruction from its first fetch cycle to just after commit
  task automatic run_instr(input logic [31:0] ins, input logic re, input logic we,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int wf, input int wm);
    mem[pc] = ins;
    core_pc = pc;
    core_mem_re = re;
    core_mem_we = we;
    core_addr = a;
    core_wdata = wd;
    #1;
    for (int i = 0; i <= wf; i++) begin
      chk("f_req", bus_req, 1);
      chk("f_we", bus_we, 0);
      chk("f_addr", bus_addr, pc);
      chk("f_en", core_en, 0);
      bus_ready = (i == wf);
      bus_rdata = (i == wf) ? mem[pc] : $urandom;
      tick();
    end
    bus_ready = 1'b0;
    chk("d_req", bus_req, 0);
    chk("d_instr", core_instr, ins);
    chk("d_en", core_en, 0);
    last_instr = ins;
    tick();
    if (re || we) begin
      if (!we && !mem.exists(a)) mem[a] = $urandom;
      for (int i = 0; i <= wm; i++) begin
        chk("m_req", bus_req, 1);
        chk("m_we", bus_we, we);
        chk("m_addr", bus_addr, a);
        if (we) chk("m_wdata", bus_wdata, wd);
        chk("m_en", core_en, 0);
        bus_ready = (i == wm);
        bus_rdata = (i == wm && !we) ? mem[a] : $urandom;
        tick();
      end
      bus_ready = 1'b0;
      if (we) mem[a] = wd;
      else exp_rdata = mem[a];
    end
    chk("c_en", core_en, 1);
    chk("c_req", bus_req, 0);
    tick();
    retired++;
    pc += 4;
    chk("instret", instret, retired % (1 << CW));
    chk("rdata", core_rdata, exp_rdata);
    chk("c_en_off", core_en, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("r_req", bus_req, 0);
    chk("r_en", core_en, 0);
    chk("r_halted", halted, 0);
    chk("r_fault", fault, 0);
    chk("r_instret", instret, 0);
    chk("r_instr", core_instr, 0);
    chk("r_rdata", core_rdata, 0);
    reset = 1'b1;
    run_instr(32'h0000_0033, 1'b0, 1'b0, '0, '0, 0, 0);
    mem[32'h100] = 32'hDEAD_BEEF;
    run_instr(32'h1000_0003, 1'b1, 1'b0, 32'h100, '0, 0, 2);
    chk("ldr_data", core_rdata, 32'hDEAD_BEEF);
    run_instr(32'h0000_0023, 1'b1, 1'b1, 32'h104, 32'h1234_5678, 1, 3);
    for (int n = 0; n < 40; n++)
      run_instr($urandom, 1'($urandom), 1'($urandom), 32'h8000 + 4 * $urandom_range(0, 7),
                $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
    halt_req = 1'b1;
    run_instr($urandom, 1'b1, 1'b0, 32'h8008, '0, 0, 1);
    chk("h_halted", halted, 1);
    chk("h_req", bus_req, 0);
    tick();
    chk("h_hold", halted, 1);
    chk("h_en", core_en, 0);
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("s1_run", halted, 0);
    run_instr($urandom, 1'b0, 1'b0, '0, '0, 1, 0);
    chk("s1_halted", halted, 1);
    step = 1'b1;
    halt_req = 1'b0;
    tick();
    step = 1'b0;
    run_instr($urandom, 1'b0, 1'b1, 32'h8010, $urandom, 0, 2);
    chk("s2_halted", halted, 1);
    tick();
    chk("resume", halted, 0);
    run_instr($urandom, 1'b0, 1'b0, '0, '0, 0, 0);
    chk("run_on", halted, 0);
    mem[pc] = 32'hA5A5_0001;
    core_pc = pc;
    core_mem_re = 1'b1;
    core_mem_we = 1'b0;
    core_addr = 32'h8000;
    #1;
    bus_ready = 1'b1;
    bus_rdata = mem[pc];
    tick();
    bus_ready = 1'b0;
    tick();
    chk("mid_req", bus_req, 1);
    reset = 1'b0;
    #1;
    chk("mr_req", bus_req, 0);
    chk("mr_instret", instret, 0);
    chk("mr_instr", core_instr, 0);
    chk("mr_rdata", core_rdata, 0);
    retired = 0;
    exp_rdata = '0;
    tick();
    reset = 1'b1;
    #1;
    chk("restart_req", bus_req, 1);
    chk("restart_addr", bus_addr, pc);
    run_instr(32'h0000_0B33, 1'b0, 1'b0, '0, '0, 1, 0);
    mem[pc] = 32'h0BAD_0000;
    core_pc = pc;
    #1;
    bus_ready = 1'b1;
    bus_err = 1'b1;
    bus_rdata = 32'hBAD0_BAD0;
    tick();
    bus_ready = 1'b0;
    bus_err = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("fe_fault", fault, 1);
      chk("fe_req", bus_req, 0);
      chk("fe_en", core_en, 0);
      chk("fe_instr", core_instr, last_instr);
      tick();
    end
    do_reset();
    for (int i = 0; i < 4; i++) begin
      chk("to_req", bus_req, 1);
      chk("to_fault", fault, 0);
      bus_ready = 1'b0;
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      chk("to_fault_set", fault, 1);
      chk("to_req_off", bus_req, 0);
      chk("to_en", core_en, 0);
      tick();
    end
    do_reset();
    mem[pc] = 32'h0000_0003;
    core_pc = pc;
    core_mem_re = 1'b1;
    core_mem_we = 1'b0;
    core_addr = 32'h8004;
    #1;
    bus_ready = 1'b1;
    bus_rdata = mem[pc];
    tick();
    bus_ready = 1'b0;
    tick();
    chk("de_req", bus_req, 1);
    chk("de_we", bus_we, 0);
    bus_ready = 1'b1;
    bus_err = 1'b1;
    bus_rdata = 32'h5555_AAAA;
    tick();
    bus_ready = 1'b0;
    bus_err = 1'b0;
    chk("de_fault", fault, 1);
    chk("de_rdata", core_rdata, 0);
    chk("de_en", core_en, 0);
    chk("de_instret", instret, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
